// File: rtl/cell_alu.sv
// Single-cell ALU with a one-entry valid/ready result register.
// Define CELL_ALU_SAT_EN to clamp ADD at 0 / 2^WIDTH-1 instead of wrapping.
module cell_alu #(
    parameter int WIDTH   = 8,
    parameter int DELTA_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               op_valid,
    output logic               op_ready,
    input  logic [1:0]         op,
    input  logic [DELTA_W-1:0] delta,
    input  logic [WIDTH-1:0]   load_data,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic               wrap
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    localparam logic [1:0] OP_ADD   = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_NOP   = 2'b11;

    logic                    state_q;
    logic                    state_d;
    logic [WIDTH-1:0]        cell_q;
    logic [WIDTH-1:0]        cell_d;
    logic                    wrap_q;
    logic                    wrap_d;
    logic                    accept;
    logic signed [WIDTH+1:0] sum;
    logic                    under;
    logic                    over;

    assign res_valid = (state_q == FULL);
    assign op_ready  = ~res_valid | res_ready;
    assign accept    = op_valid & op_ready;

    // Two guard bits: top bit flags a negative sum, next one a carry out.
    assign sum = $signed({2'b00, cell_q})
               + $signed({{(WIDTH+2-DELTA_W){delta[DELTA_W-1]}}, delta});
    assign under = sum[WIDTH+1];
    assign over  = ~sum[WIDTH+1] & sum[WIDTH];

    always_comb begin
        state_d = state_q;
        cell_d  = cell_q;
        wrap_d  = wrap_q;
        if (accept) begin
            state_d = FULL;
            unique case (op)
                OP_ADD: begin
`ifdef CELL_ALU_SAT_EN
                    if (under)
                        cell_d = '0;
                    else if (over)
                        cell_d = '1;
                    else
                        cell_d = sum[WIDTH-1:0];
`else
                    cell_d = sum[WIDTH-1:0];
`endif
                    wrap_d = under | over;
                end
                OP_CLEAR: begin
                    cell_d = '0;
                    wrap_d = 1'b0;
                end
                OP_LOAD: begin
                    cell_d = load_data;
                    wrap_d = 1'b0;
                end
                OP_NOP: begin
                    wrap_d = 1'b0;
                end
            endcase
        end else if (res_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cell_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cell_q  <= cell_d;
            wrap_q  <= wrap_d;
        end
    end

    // The result register is the cell itself: it only changes on accept.
    assign result = cell_q;
    assign zero   = (cell_q == '0);
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_cell_alu.sv
// Bench for cell_alu: directed vector table, handshake/reset sequences,
// and randomized traffic against an integer reference model.
module tb_cell_alu;

    localparam int W   = 8;
    localparam int DW  = 4;
    localparam int MAX = (1 << W) - 1;

    localparam logic [1:0] ADD = 2'b00;
    localparam logic [1:0] CLR = 2'b01;
    localparam logic [1:0] LD  = 2'b10;
    localparam logic [1:0] NOP = 2'b11;

    logic          clk;
    logic          rst_n;
    logic          op_valid;
    logic          op_ready;
    logic [1:0]    op;
    logic [DW-1:0] delta;
    logic [W-1:0]  load_data;
    logic          res_valid;
    logic          res_ready;
    logic [W-1:0]  result;
    logic          zero;
    logic          wrap;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]    op;
        logic [DW-1:0] d;
        logic [W-1:0]  ld;
        logic [W-1:0]  er;
        logic          ew;
        string         nm;
    } vec_t;

    vec_t tbl[$];

    int  mcell;
    bit  mfull;
    bit  mwrap;

    cell_alu #(.WIDTH(W), .DELTA_W(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op_valid  (op_valid),
        .op_ready  (op_ready),
        .op        (op),
        .delta     (delta),
        .load_data (load_data),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .result    (result),
        .zero      (zero),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input int er, input int ew,
                           input int ev);
        chk({nm, ".result"}, int'(result), er);
        chk({nm, ".zero"}, int'(zero), int'(er == 0));
        chk({nm, ".wrap"}, int'(wrap), ew);
        chk({nm, ".res_valid"}, int'(res_valid), ev);
    endtask

    task automatic add_vec(input logic [1:0] o, input logic [DW-1:0] d,
                           input logic [W-1:0] ld, input logic [W-1:0] er,
                           input logic ew, input string nm);
        vec_t v;
        v.op = o;
        v.d  = d;
        v.ld = ld;
        v.er = er;
        v.ew = ew;
        v.nm = nm;
        tbl.push_back(v);
    endtask

    // Called at a negedge: drive, cross one rising edge, return at next negedge.
    task automatic step(input logic ov, input logic [1:0] o,
                        input logic [DW-1:0] d, input logic [W-1:0] ld,
                        input logic rr);
        op_valid  = ov;
        op        = o;
        delta     = d;
        load_data = ld;
        res_ready = rr;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic int sx(input logic [DW-1:0] d);
        int v;
        v = int'(d);
        if (d[DW-1])
            v = v - (1 << DW);
        return v;
    endfunction

    task automatic model_op(input logic [1:0] o, input logic [DW-1:0] d,
                            input logic [W-1:0] ld);
        int s;
        mwrap = 1'b0;
        case (o)
            ADD: begin
                s = mcell + sx(d);
                if (s < 0 || s > MAX) begin
                    mwrap = 1'b1;
`ifdef CELL_ALU_SAT_EN
                    s = (s < 0) ? 0 : MAX;
`endif
                end
                mcell = (s + MAX + 1) % (MAX + 1);
            end
            CLR: mcell = 0;
            LD:  mcell = int'(ld);
            default: ;
        endcase
    endtask

    initial begin
        logic ov;
        logic rr;
        logic [1:0] o;
        logic [DW-1:0] d;
        logic [W-1:0] ld;

        rst_n     = 1'b0;
        op_valid  = 1'b0;
        op        = NOP;
        delta     = '0;
        load_data = '0;
        res_ready = 1'b1;

        add_vec(ADD, 4'd3, 8'h00, 8'h03, 1'b0, "add3");
        add_vec(LD,  4'd0, 8'hFE, 8'hFE, 1'b0, "ldFE");
`ifdef CELL_ALU_SAT_EN
        add_vec(ADD, 4'd3, 8'h00, 8'hFF, 1'b1, "ovf");
`else
        add_vec(ADD, 4'd3, 8'h00, 8'h01, 1'b1, "ovf");
`endif
        add_vec(CLR, 4'd0, 8'h77, 8'h00, 1'b0, "clr");
`ifdef CELL_ALU_SAT_EN
        add_vec(ADD, 4'hF, 8'h00, 8'h00, 1'b1, "unf");
`else
        add_vec(ADD, 4'hF, 8'h00, 8'hFF, 1'b1, "unf");
`endif
        add_vec(LD,  4'd0, 8'h10, 8'h10, 1'b0, "ld10");
        add_vec(ADD, 4'd1, 8'h00, 8'h11, 1'b0, "b2b1");
        add_vec(ADD, 4'd1, 8'h00, 8'h12, 1'b0, "b2b2");
        add_vec(ADD, 4'd1, 8'h00, 8'h13, 1'b0, "b2b3");
        add_vec(ADD, 4'd1, 8'h00, 8'h14, 1'b0, "b2b4");
        add_vec(ADD, 4'd0, 8'h99, 8'h14, 1'b0, "add0");
        add_vec(NOP, 4'd5, 8'h99, 8'h14, 1'b0, "nop");
        add_vec(ADD, 4'h8, 8'h00, 8'h0C, 1'b0, "addm8");
        add_vec(ADD, 4'h7, 8'h00, 8'h13, 1'b0, "add7");
        add_vec(LD,  4'd0, 8'h00, 8'h00, 1'b0, "ld00");
`ifdef CELL_ALU_SAT_EN
        add_vec(ADD, 4'h8, 8'h00, 8'h00, 1'b1, "unf8");
`else
        add_vec(ADD, 4'h8, 8'h00, 8'hF8, 1'b1, "unf8");
`endif
        add_vec(LD,  4'd0, 8'hF9, 8'hF9, 1'b0, "ldF9");
`ifdef CELL_ALU_SAT_EN
        add_vec(ADD, 4'h7, 8'h00, 8'hFF, 1'b1, "ovf7");
`else
        add_vec(ADD, 4'h7, 8'h00, 8'h00, 1'b1, "ovf7");
`endif

        // Reset state, checked while reset is still held.
        @(negedge clk);
        chk_out("rst", 0, 0, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk("rst.op_ready", int'(op_ready), 1);
        chk_out("post_rst", 0, 0, 0);

        foreach (tbl[i]) begin
            step(1'b1, tbl[i].op, tbl[i].d, tbl[i].ld, 1'b1);
            chk_out(tbl[i].nm, int'(tbl[i].er), int'(tbl[i].ew), 1);
        end

        // Stall: result held, op_ready low, offered LOAD ignored.
        op_valid  = 1'b1;
        op        = LD;
        load_data = 8'hAA;
        res_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("stall.op_ready", int'(op_ready), 0);
`ifdef CELL_ALU_SAT_EN
            chk_out("stall", 8'hFF, 1, 1);
`else
            chk_out("stall", 8'h00, 1, 1);
`endif
        end
        res_ready = 1'b1;
        #1 chk("unstall.op_ready", int'(op_ready), 1);
        @(posedge clk);
        @(negedge clk);
        chk_out("unstall", 8'hAA, 0, 1);
        step(1'b1, ADD, 4'd1, 8'h00, 1'b1);
        chk_out("held_cell", 8'hAB, 0, 1);

        // Drain to EMPTY.
        step(1'b0, ADD, 4'd7, 8'h00, 1'b1);
        chk_out("drain", 8'hAB, 0, 0);
        chk("drain.op_ready", int'(op_ready), 1);

        // Async reset while a LOAD result is held.
        step(1'b1, LD, 4'd0, 8'h55, 1'b0);
        chk_out("ld55", 8'h55, 0, 1);
        op_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1 chk_out("async_rst", 0, 0, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        step(1'b1, ADD, 4'd1, 8'h00, 1'b1);
        chk_out("rst_add1", 8'h01, 0, 1);

        mcell = 1;
        mfull = 1'b1;
        mwrap = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ov = 1'($urandom_range(0, 3) != 0);
            rr = 1'($urandom_range(0, 2) != 0);
            o  = 2'($urandom_range(0, 3));
            if (o == CLR && $urandom_range(0, 1) == 1)
                o = ADD;
            d  = DW'($urandom_range(0, (1 << DW) - 1));
            case ($urandom_range(0, 3))
                0: ld = 8'hFF;
                1: ld = 8'h02;
                default: ld = W'($urandom_range(0, MAX));
            endcase
            op_valid  = ov;
            op        = o;
            delta     = d;
            load_data = ld;
            res_ready = rr;
            #1 chk("rnd.op_ready", int'(op_ready), int'(!mfull || rr));
            @(posedge clk);
            if (ov && (!mfull || rr)) begin
                model_op(o, d, ld);
                mfull = 1'b1;
            end else if (rr) begin
                mfull = 1'b0;
            end
            @(negedge clk);
            chk_out("rnd", mcell, int'(mwrap), int'(mfull));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
